// File: rtl/keypad_scanner.sv
// keypad_scanner
// Scans a 4x3 active-low matrix keypad, debounces both press and release,
// and presents the held key as a 4-bit code (0-9 digits, 10 = no key,
// 11 = '*', 12 = '#') with a one-cycle pulse for each newly accepted press.
//
// Ports
//   clock      system clock, all state updates on the rising edge
//   reset      synchronous, active-high
//   row_in     keypad rows, active-low, already synchronised
//   col_out    column drive, active-low, at most one column low
//   key        current debounced key code
//   key_valid  one-cycle pulse when a new press is accepted
module keypad_scanner #(
    parameter int SETTLE   = 2,
    parameter int DEBOUNCE = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] row_in,
    output logic [2:0] col_out,
    output logic [3:0] key,
    output logic       key_valid
);

    localparam int SW = $clog2(SETTLE + 1);
    localparam int DW = $clog2(DEBOUNCE + 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);
    localparam logic [DW-1:0] DB_LAST     = DW'(DEBOUNCE - 1);
    localparam logic [DW-1:0] DB_MAX      = DW'(DEBOUNCE);
    localparam logic [DW-1:0] DB_ONE      = DW'(1);
    localparam logic [3:0]    NOKEY       = 4'd10;

    typedef enum logic [1:0] {
        SCAN,
        PRESS_DB,
        HELD,
        REL_DB
    } state_t;

    state_t        r_state;
    state_t        w_stateNext;
    logic [1:0]    r_col;
    logic [1:0]    w_colNext;
    logic [1:0]    w_colInc;
    logic [SW-1:0] r_settle;
    logic [SW-1:0] w_settleNext;
    logic [DW-1:0] r_count;
    logic [DW-1:0] w_countNext;
    logic [DW-1:0] w_countInc;
    logic [1:0]    r_row;
    logic [1:0]    w_rowNext;
    logic [1:0]    w_lowRow;
    logic [3:0]    r_pattern;
    logic [3:0]    w_patternNext;
    logic [3:0]    r_key;
    logic [3:0]    w_keyNext;
    logic          r_keyValid;
    logic          w_keyValidNext;
    logic [3:0]    w_code;

    assign col_out   = ~(3'b001 << r_col);
    assign key       = r_key;
    assign key_valid = r_keyValid;

    // Column after the current one, wrapping from column 2 back to column 0,
    // and the debounce count advanced by one but never beyond DEBOUNCE.
    assign w_colInc   = (r_col == 2'd2) ? 2'd0 : r_col + 2'd1;
    assign w_countInc = (r_count == DB_MAX) ? r_count : r_count + DB_ONE;

    // When several rows are low in the sampled column, the lowest-numbered
    // row is the one we latch and watch for the rest of the press.
    always_comb begin
        w_lowRow = 2'd0;
        if (!row_in[0]) begin
            w_lowRow = 2'd0;
        end else if (!row_in[1]) begin
            w_lowRow = 2'd1;
        end else if (!row_in[2]) begin
            w_lowRow = 2'd2;
        end else if (!row_in[3]) begin
            w_lowRow = 2'd3;
        end
    end

    // Keypad legend for the latched row/column. Rows 0-2 carry digits 1-9,
    // the bottom row carries '*', 0 and '#'.
    always_comb begin
        w_code = NOKEY;
        case ({r_row, r_col})
            4'b00_00: w_code = 4'd1;
            4'b00_01: w_code = 4'd2;
            4'b00_10: w_code = 4'd3;
            4'b01_00: w_code = 4'd4;
            4'b01_01: w_code = 4'd5;
            4'b01_10: w_code = 4'd6;
            4'b10_00: w_code = 4'd7;
            4'b10_01: w_code = 4'd8;
            4'b10_10: w_code = 4'd9;
            4'b11_00: w_code = 4'd11;
            4'b11_01: w_code = 4'd0;
            4'b11_10: w_code = 4'd12;
            default:  w_code = NOKEY;
        endcase
    end

    // Next-state logic. SCAN walks the columns and samples the rows once per
    // settle window; PRESS_DB demands DEBOUNCE identical row patterns before
    // the key is published; HELD watches only the latched row; REL_DB demands
    // DEBOUNCE high samples of that row before the key is withdrawn. A failed
    // press returns to the same column so the key is re-examined at once,
    // while a completed release moves on so another column gets a turn.
    always_comb begin
        w_stateNext    = r_state;
        w_colNext      = r_col;
        w_settleNext   = r_settle;
        w_countNext    = r_count;
        w_rowNext      = r_row;
        w_patternNext  = r_pattern;
        w_keyNext      = r_key;
        w_keyValidNext = 1'b0;
        unique case (r_state)
            SCAN: begin
                if (r_settle == SETTLE_LAST) begin
                    w_settleNext = '0;
                    if (row_in == 4'hF) begin
                        w_colNext = w_colInc;
                    end else begin
                        w_rowNext     = w_lowRow;
                        w_patternNext = row_in;
                        w_countNext   = DB_ONE;
                        w_stateNext   = PRESS_DB;
                    end
                end else begin
                    w_settleNext = r_settle + SW'(1);
                end
            end
            PRESS_DB: begin
                if (row_in == r_pattern) begin
                    w_countNext = w_countInc;
                    if (r_count >= DB_LAST) begin
                        w_stateNext    = HELD;
                        w_keyNext      = w_code;
                        w_keyValidNext = 1'b1;
                    end
                end else begin
                    w_stateNext  = SCAN;
                    w_settleNext = '0;
                end
            end
            HELD: begin
                if (row_in[r_row]) begin
                    w_countNext = DB_ONE;
                    w_stateNext = REL_DB;
                end
            end
            REL_DB: begin
                if (row_in[r_row]) begin
                    w_countNext = w_countInc;
                    if (r_count >= DB_LAST) begin
                        w_stateNext  = SCAN;
                        w_keyNext    = NOKEY;
                        w_colNext    = w_colInc;
                        w_settleNext = '0;
                    end
                end else begin
                    w_stateNext = HELD;
                end
            end
            default: begin
                w_stateNext = SCAN;
            end
        endcase
    end

    // State register. Reset wins in every state, so an interrupted press
    // never produces a pulse and the key returns to NOKEY on the next edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= SCAN;
            r_col      <= 2'd0;
            r_settle   <= '0;
            r_count    <= '0;
            r_row      <= 2'd0;
            r_pattern  <= 4'hF;
            r_key      <= NOKEY;
            r_keyValid <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_col      <= w_colNext;
            r_settle   <= w_settleNext;
            r_count    <= w_countNext;
            r_row      <= w_rowNext;
            r_pattern  <= w_patternNext;
            r_key      <= w_keyNext;
            r_keyValid <= w_keyValidNext;
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner
// Drives keypad_scanner through a simulated 4x3 keypad (rows respond to the
// columns the scanner drives) and compares every cycle against a reference
// model built from scan timing arithmetic and run lengths of row samples.
module tb_keypad_scanner;

    localparam int SETTLE   = 2;
    localparam int DEBOUNCE = 4;
    localparam logic [3:0] NOKEY = 4'd10;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  rowIn;
    logic [2:0]  colOut;
    logic [3:0]  key;
    logic        keyValid;

    logic [11:0] pressed;
    int          vectorCount = 0;
    int          failCount   = 0;
    int          pulseCount  = 0;
    bit          checkEnable = 1'b0;

    // Reference model state: scanning position is derived from the cycle
    // number since the scan last (re)started, a press is tracked as a run
    // length of identical samples, a release as a run length of high samples.
    int          mCycle    = 0;
    int          mScanBase = 0;
    int          mScanCol  = 0;
    bit          mCaptured = 1'b0;
    bit          mAccepted = 1'b0;
    bit          mValid    = 1'b0;
    logic [3:0]  mPattern  = 4'hF;
    logic [3:0]  mKey      = NOKEY;
    int          mRow      = 0;
    int          mCol      = 0;
    int          mRun      = 0;

    keypad_scanner #(
        .SETTLE   (SETTLE),
        .DEBOUNCE (DEBOUNCE)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .row_in    (rowIn),
        .col_out   (colOut),
        .key       (key),
        .key_valid (keyValid)
    );

    always #5 clock = ~clock;

    // Physical keypad: a pressed key at (r,c) pulls row r low while column c
    // is driven low.
    always_comb begin
        rowIn = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (pressed[r*3 + c] && !colOut[c]) begin
                    rowIn[r] = 1'b0;
                end
            end
        end
    end

    function automatic logic [3:0] keyCode(input int r, input int c);
        if (r < 3) return 4'(r*3 + c + 1);
        if (c == 0) return 4'd11;
        if (c == 1) return 4'd0;
        return 4'd12;
    endfunction

    function automatic logic [11:0] keyMask(input int code);
        int idx;
        case (code)
            0:       idx = 10;
            11:      idx = 9;
            12:      idx = 11;
            default: idx = code - 1;
        endcase
        return 12'(1) << idx;
    endfunction

    function automatic int lowestLow(input logic [3:0] rows);
        for (int r = 0; r < 4; r++) begin
            if (!rows[r]) return r;
        end
        return 0;
    endfunction

    function automatic logic [2:0] expectedColOut();
        logic [2:0] v;
        int c;
        v = 3'b111;
        if (mCaptured) c = mCol;
        else c = (mScanCol + (mCycle - mScanBase) / SETTLE) % 3;
        v[c] = 1'b0;
        return v;
    endfunction

    // Reference model advance at each rising edge, using the row value the
    // design sees at that same edge.
    always @(posedge clock) begin : modelStep
        int p;
        mValid = 1'b0;
        if (reset) begin
            mCaptured = 1'b0;
            mAccepted = 1'b0;
            mKey      = NOKEY;
            mRun      = 0;
            mScanCol  = 0;
            mScanBase = mCycle + 1;
        end else if (!mCaptured) begin
            p = mCycle - mScanBase;
            if ((p % SETTLE) == SETTLE - 1 && rowIn != 4'hF) begin
                mCol      = (mScanCol + p / SETTLE) % 3;
                mRow      = lowestLow(rowIn);
                mPattern  = rowIn;
                mRun      = 1;
                mCaptured = 1'b1;
                mAccepted = 1'b0;
            end
        end else if (!mAccepted) begin
            if (rowIn == mPattern) begin
                mRun++;
                if (mRun == DEBOUNCE) begin
                    mAccepted = 1'b1;
                    mKey      = keyCode(mRow, mCol);
                    mValid    = 1'b1;
                    mRun      = 0;
                end
            end else begin
                mCaptured = 1'b0;
                mScanCol  = mCol;
                mScanBase = mCycle + 1;
            end
        end else begin
            if (rowIn[mRow]) begin
                mRun++;
                if (mRun == DEBOUNCE) begin
                    mKey      = NOKEY;
                    mCaptured = 1'b0;
                    mAccepted = 1'b0;
                    mRun      = 0;
                    mScanCol  = (mCol + 1) % 3;
                    mScanBase = mCycle + 1;
                end
            end else begin
                mRun = 0;
            end
        end
        mCycle++;
    end

    task automatic checkOutput(input string tag, input logic [3:0] observed, input logic [3:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the rising edge.
    always @(negedge clock) begin
        if (checkEnable) begin
            checkOutput("col", {1'b0, colOut}, {1'b0, expectedColOut()});
            checkOutput("key", key, mKey);
            checkOutput("valid", {3'b000, keyValid}, {3'b000, mValid});
        end
        if (keyValid) pulseCount++;
    end

    task automatic applyStimulus(input logic [11:0] mask, input int cycles);
        pressed = mask;
        repeat (cycles) @(negedge clock);
    endtask

    task automatic waitColumn(input int c);
        int n;
        logic [2:0] want;
        n = 0;
        want = 3'b111;
        want[c] = 1'b0;
        while (colOut != want && n < 50) begin
            @(negedge clock);
            n++;
        end
        checkOutput("waitCol", {1'b0, colOut}, {1'b0, want});
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "Col"}, {1'b0, colOut}, 4'b0110);
        checkOutput({tag, "Key"}, key, NOKEY);
        checkOutput({tag, "Valid"}, {3'b000, keyValid}, 4'd0);
    endtask

    initial begin
        int p0;
        int n;
        int kind;
        int dur;
        logic [11:0] m;

        pressed = '0;
        reset   = 1'b1;
        repeat (3) @(negedge clock);
        checkResetState("rst");
        checkEnable = 1'b1;
        reset = 1'b0;
        applyStimulus('0, 14);

        p0 = pulseCount;
        applyStimulus(keyMask(5), 20);
        checkOutput("press5", key, 4'd5);
        applyStimulus('0, 10);
        checkOutput("release5", key, NOKEY);
        checkOutput("pulses5", 4'(pulseCount - p0), 4'd1);

        p0 = pulseCount;
        waitColumn(2);
        applyStimulus(keyMask(3), 2);
        applyStimulus('0, 1);
        applyStimulus(keyMask(3), 20);
        checkOutput("bounce3", key, 4'd3);
        checkOutput("pulses3", 4'(pulseCount - p0), 4'd1);
        applyStimulus('0, 10);

        p0 = pulseCount;
        applyStimulus(keyMask(0), 20);
        checkOutput("press0", key, 4'd0);
        applyStimulus('0, 2);
        applyStimulus(keyMask(0), 10);
        checkOutput("relBounce0", key, 4'd0);
        checkOutput("pulses0", 4'(pulseCount - p0), 4'd1);
        applyStimulus('0, 10);
        checkOutput("release0", key, NOKEY);

        applyStimulus(keyMask(1) | keyMask(7), 20);
        checkOutput("multiRow", key, 4'd1);
        applyStimulus('0, 10);
        applyStimulus(keyMask(11), 20);
        checkOutput("star", key, 4'd11);
        applyStimulus('0, 10);

        p0 = pulseCount;
        pressed = keyMask(5);
        n = 0;
        while (!(mCaptured && !mAccepted) && n < 40) begin
            @(negedge clock);
            n++;
        end
        checkOutput("waitPressDb", {3'b000, mCaptured && !mAccepted}, 4'd1);
        reset = 1'b1;
        @(negedge clock);
        checkResetState("rstPress");
        reset = 1'b0;
        n = 0;
        while (!mAccepted && n < 40) begin
            @(negedge clock);
            n++;
        end
        checkOutput("waitHeld", key, 4'd5);
        reset = 1'b1;
        @(negedge clock);
        checkResetState("rstHeld");
        reset = 1'b0;
        applyStimulus('0, 12);
        checkOutput("pulsesRst", 4'(pulseCount - p0), 4'd1);

        p0 = pulseCount;
        foreach (m[i]) begin
        end
        for (int i = 0; i < 4; i++) begin
            int d;
            d = (i < 2) ? 1 : i;
            applyStimulus(keyMask(d), 20);
            checkOutput("entryDigit", key, 4'(d));
            applyStimulus('0, 10);
            checkOutput("entryGap", key, NOKEY);
        end
        checkOutput("entryPulses", 4'(pulseCount - p0), 4'd4);

        for (int i = 0; i < 80; i++) begin
            kind = $urandom_range(0, 9);
            dur  = $urandom_range(1, 24);
            if (kind < 6) begin
                m = 12'(1) << $urandom_range(0, 11);
            end else if (kind < 8) begin
                m = (12'(1) << $urandom_range(0, 11)) | (12'(1) << $urandom_range(0, 11));
            end else begin
                m = '0;
            end
            if (kind == 9) begin
                reset = 1'b1;
                applyStimulus(m, 1);
                reset = 1'b0;
            end
            applyStimulus(m, dur);
        end
        applyStimulus('0, 14);
        checkOutput("finalIdle", key, NOKEY);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, failCount);
        $finish;
    end

endmodule
